// File: rtl/esc_command_sequencer.sv
// ---------------------------------------------------------------------------
// esc_command_sequencer
//
// Purpose:
//   Gatekeeper between the assistance/throttle command sources and the motor
//   PWM generator. It selects the active command source, enforces the ESC
//   arming sequence, slew-limits the 10-bit duty request and applies the
//   brake and fault overrides. Decisions are paced by an internal control
//   tick derived from c50m. Brake and FaultIn act on every clock.
//
// Ports:
//   c50m          in   1   system clock
//   reset         in   1   synchronous, active-high reset
//   Enable        in   1   rider/system enable
//   TestMode      in   1   1 = ThrottleTest drives the target, 0 = AssistReq
//   AssistReq     in  12   assistance command
//   AssistValid   in   1   one-cycle pulse on each AssistReq update
//   ThrottleTest  in  12   bench throttle command
//   Brake         in   1   brake lever
//   FaultIn       in   1   external fault
//   MotorSignal   out 10   duty request to the PWM generator
//   Armed         out  1   high in IDLE, RUN and BRAKE
//   State         out  3   ARMING=0 IDLE=1 RUN=2 BRAKE=3 FAULT=4
//   TickPulse     out  1   one-cycle pulse on each control tick
//
// Build option:
//   WATCHDOG_EN - when defined, RUN with TestMode=0 faults if AssistValid
//                 has not pulsed for WDOG_TICKS ticks. When undefined there
//                 is no watchdog and AssistValid is ignored.
// ---------------------------------------------------------------------------
module esc_command_sequencer #(
   parameter int TICK_DIV   = 2500,
   parameter int ARM_TICKS  = 40000,
   parameter int RAMP_UP    = 4,
   parameter int RAMP_DOWN  = 16,
   parameter int WDOG_TICKS = 2000
) (
   input  logic        c50m,
   input  logic        reset,
   input  logic        Enable,
   input  logic        TestMode,
   input  logic [11:0] AssistReq,
   input  logic        AssistValid,
   input  logic [11:0] ThrottleTest,
   input  logic        Brake,
   input  logic        FaultIn,
   output logic [9:0]  MotorSignal,
   output logic        Armed,
   output logic [2:0]  State,
   output logic        TickPulse
);

   typedef enum logic [2:0] {
      ST_ARMING = 3'd0,
      ST_IDLE   = 3'd1,
      ST_RUN    = 3'd2,
      ST_BRAKE  = 3'd3,
      ST_FAULT  = 3'd4
   } state_t;

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   localparam int AW = (ARM_TICKS > 1) ? $clog2(ARM_TICKS + 1) : 1;
   localparam logic [AW-1:0] ARM_LAST = AW'(ARM_TICKS - 1);

   // Step sizes clamped to the duty range so they fit the 10-bit datapath
   localparam logic [9:0] RAMP_UP_C   = 10'((RAMP_UP   > 1023) ? 1023 : RAMP_UP);
   localparam logic [9:0] RAMP_DOWN_C = 10'((RAMP_DOWN > 1023) ? 1023 : RAMP_DOWN);

   // Moves cur toward tgt by at most one ramp step. The large-step branch is
   // only taken when the step lands strictly before tgt, so it can neither
   // overshoot nor wrap past 0 or 1023.
   function automatic logic [9:0] ramp_step(input logic [9:0] cur, input logic [9:0] tgt);
      logic [9:0] diff;
      logic [9:0] res;
      diff = 10'd0;
      res  = cur;
      if (tgt > cur) begin
         diff = tgt - cur;
         res  = (diff > RAMP_UP_C) ? (cur + RAMP_UP_C) : tgt;
      end else if (tgt < cur) begin
         diff = cur - tgt;
         res  = (diff > RAMP_DOWN_C) ? (cur - RAMP_DOWN_C) : tgt;
      end else begin
         res  = cur;
      end
      return res;
   endfunction

   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          tick_q, tick_d;
   state_t        state_q, state_d;
   logic [9:0]    motor_q, motor_d;
   logic          armed_q, armed_d;
   logic [AW-1:0] arm_q, arm_d;
   logic [9:0]    target_s;
   logic          wdog_trip_s;
   logic          fault_now_s;
   logic          unused_s;

   // Only the upper ten bits of the 12-bit commands form the target
   assign unused_s = ^{AssistReq[1:0], ThrottleTest[1:0]};
   assign target_s = TestMode ? ThrottleTest[11:2] : AssistReq[11:2];

   // Watchdog trips share the external fault path and its priority
   assign fault_now_s = FaultIn | wdog_trip_s;

   // Prescaler next value; the tick flag is high while the count sits at 0
   always_comb begin
      tick_cnt_d = tick_cnt_q;
      tick_d     = 1'b0;
      if (tick_cnt_q == TICK_LAST) begin
         tick_cnt_d = {TW{1'b0}};
         tick_d     = 1'b1;
      end else begin
         tick_cnt_d = tick_cnt_q + TW'(1);
         tick_d     = 1'b0;
      end
   end

   // Prescaler registers
   always_ff @(posedge c50m) begin
      if (reset) begin
         tick_cnt_q <= {TW{1'b0}};
         tick_q     <= 1'b0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         tick_q     <= tick_d;
      end
   end

   // Arm counter: counts consecutive enabled ticks in ARMING, zero elsewhere
   always_comb begin
      arm_d = arm_q;
      if ((state_q != ST_ARMING) || !Enable) begin
         arm_d = {AW{1'b0}};
      end else if (tick_q) begin
         if (arm_q == ARM_LAST) begin
            arm_d = {AW{1'b0}};
         end else begin
            arm_d = arm_q + AW'(1);
         end
      end else begin
         arm_d = arm_q;
      end
   end

   // FSM state register
   always_ff @(posedge c50m) begin
      if (reset) begin
         state_q <= ST_ARMING;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: faults and brake act every clock, the rest on ticks
   always_comb begin
      state_d = state_q;
      if (fault_now_s) begin
         state_d = ST_FAULT;
      end else begin
         case (state_q)
            ST_ARMING: begin
               if (tick_q && Enable && (arm_q == ARM_LAST)) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_ARMING;
               end
            end
            ST_IDLE: begin
               if (Brake) begin
                  state_d = ST_BRAKE;
               end else if (tick_q && Enable && (target_s != 10'd0)) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (Brake) begin
                  state_d = ST_BRAKE;
               end else if (tick_q && !Enable) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_BRAKE: begin
               if (tick_q && !Brake) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_BRAKE;
               end
            end
            ST_FAULT: begin
               // Latched: leaving needs the fault gone and the rider disabled
               if (tick_q && !FaultIn && !Enable) begin
                  state_d = ST_ARMING;
               end else begin
                  state_d = ST_FAULT;
               end
            end
            default: begin
               state_d = ST_FAULT;
            end
         endcase
      end
   end

   // FSM outputs: only RUN drives a non-zero duty, and only on ticks
   always_comb begin
      motor_d = 10'd0;
      if (fault_now_s) begin
         motor_d = 10'd0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (Brake) begin
                  motor_d = 10'd0;
               end else if (!tick_q) begin
                  motor_d = motor_q;
               end else if (!Enable) begin
                  motor_d = 10'd0;
               end else begin
                  motor_d = ramp_step(motor_q, target_s);
               end
            end
            default: begin
               motor_d = 10'd0;
            end
         endcase
      end
      armed_d = (state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_BRAKE);
   end

   // Output and arm-counter registers
   always_ff @(posedge c50m) begin
      if (reset) begin
         motor_q <= 10'd0;
         armed_q <= 1'b0;
         arm_q   <= {AW{1'b0}};
      end else begin
         motor_q <= motor_d;
         armed_q <= armed_d;
         arm_q   <= arm_d;
      end
   end

`ifdef WATCHDOG_EN
   localparam int WW = (WDOG_TICKS > 1) ? $clog2(WDOG_TICKS) : 1;
   localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_TICKS - 1);

   logic [WW-1:0] wdog_q, wdog_d;
   logic          wdog_active_s;

   assign wdog_active_s = (state_q == ST_RUN) && !TestMode;
   // An AssistValid on the expiring tick still counts as a fresh update
   assign wdog_trip_s   = wdog_active_s && tick_q && !AssistValid && (wdog_q == WDOG_LAST);

   // Watchdog next value: held at zero unless RUN is fed from AssistReq
   always_comb begin
      wdog_d = wdog_q;
      if (!wdog_active_s || AssistValid) begin
         wdog_d = {WW{1'b0}};
      end else if (tick_q) begin
         if (wdog_q == WDOG_LAST) begin
            wdog_d = {WW{1'b0}};
         end else begin
            wdog_d = wdog_q + WW'(1);
         end
      end else begin
         wdog_d = wdog_q;
      end
   end

   // Watchdog register
   always_ff @(posedge c50m) begin
      if (reset) begin
         wdog_q <= {WW{1'b0}};
      end else begin
         wdog_q <= wdog_d;
      end
   end
`else
   logic wdog_unused_s;

   assign wdog_trip_s   = 1'b0;
   assign wdog_unused_s = AssistValid & (WDOG_TICKS != 0);
`endif

   assign MotorSignal = motor_q;
   assign Armed       = armed_q;
   assign State       = state_q;
   assign TickPulse   = tick_q;

endmodule
